// File: rtl/load_ext_unit_pkg.sv
// ============================================================================
// load_ext_unit_pkg : MIPS load opcodes, FSM state type and decode helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package load_ext_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lane);
    case (op)
      OP_LW:         return lane != 2'b00;
      OP_LH, OP_LHU: return lane[0];
      default:       return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_data_ext.sv
// ============================================================================
// load_data_ext : selects the addressed byte/half of a bus word and extends it
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_data_ext
  import load_ext_unit_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];

    case (op)
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'h0, byte_sel};
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'h0, half_sel};
      default: result = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_ext_unit.sv
// ============================================================================
// load_ext_unit : executes MIPS loads over a variable-latency read bus and
//                 returns the extended lane for writeback
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_ext_unit
  import load_ext_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [31:0] ld_instr,
  input  logic [31:0] ld_addr,
  output logic        ld_ready,
  input  logic        flush,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rvalid,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rt,
  output logic        adel,
  output logic        bus_err,
  output logic        busy
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [7:0]  timer, timer_nx;
  logic [5:0]  op_q, op_nx;
  logic [4:0]  rt_q, rt_nx;
  logic [1:0]  lane_q, lane_nx;
  logic        bus_req_nx;
  logic [31:0] bus_addr_nx;
  logic        wb_valid_nx;
  logic [31:0] wb_data_nx;
  logic [4:0]  wb_rt_nx;
  logic        adel_nx;
  logic        bus_err_nx;
  logic [31:0] ext_data;
  logic [5:0]  ld_op;
  logic        unused_instr_bits;

  assign ld_op             = ld_instr[31:26];
  assign unused_instr_bits = ^{ld_instr[25:21], ld_instr[15:0]};
  assign ld_ready          = (state == ST_IDLE);
  assign busy              = ~ld_ready;

  load_data_ext u_ext (
    .op     (op_q),
    .lane   (lane_q),
    .word   (bus_rdata),
    .result (ext_data)
  );

  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    op_nx       = op_q;
    rt_nx       = rt_q;
    lane_nx     = lane_q;
    bus_req_nx  = bus_req;
    bus_addr_nx = bus_addr;
    wb_valid_nx = 1'b0;
    wb_data_nx  = wb_data;
    wb_rt_nx    = wb_rt;
    adel_nx     = 1'b0;
    bus_err_nx  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (ld_valid && is_load(ld_op)) begin
          if (is_misaligned(ld_op, ld_addr[1:0])) begin
            adel_nx = 1'b1;
          end else begin
            op_nx       = ld_op;
            rt_nx       = ld_instr[20:16];
            lane_nx     = ld_addr[1:0];
            bus_req_nx  = 1'b1;
            bus_addr_nx = {ld_addr[31:2], 2'b00};
            timer_nx    = 8'd0;
            state_nx    = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        timer_nx = timer + 8'd1;
        // Data arriving together with a flush belongs to a killed load.
        if (bus_rvalid) begin
          bus_req_nx = 1'b0;
          timer_nx   = 8'd0;
          state_nx   = ST_IDLE;
          if (!flush) begin
            wb_valid_nx = 1'b1;
            wb_data_nx  = ext_data;
            wb_rt_nx    = rt_q;
          end
        end else if (flush) begin
          bus_req_nx = 1'b0;
          timer_nx   = 8'd0;
          state_nx   = ST_DRAIN;
        end else if (timer == TIMER_LAST) begin
          bus_req_nx = 1'b0;
          bus_err_nx = 1'b1;
          timer_nx   = 8'd0;
          state_nx   = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        timer_nx = timer + 8'd1;
        if (bus_rvalid || (timer == TIMER_LAST)) begin
          timer_nx = 8'd0;
          state_nx = ST_IDLE;
        end
      end

      default: begin
        bus_req_nx = 1'b0;
        timer_nx   = 8'd0;
        state_nx   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      timer    <= 8'd0;
      op_q     <= 6'd0;
      rt_q     <= 5'd0;
      lane_q   <= 2'd0;
      bus_req  <= 1'b0;
      bus_addr <= 32'd0;
      wb_valid <= 1'b0;
      wb_data  <= 32'd0;
      wb_rt    <= 5'd0;
      adel     <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      op_q     <= op_nx;
      rt_q     <= rt_nx;
      lane_q   <= lane_nx;
      bus_req  <= bus_req_nx;
      bus_addr <= bus_addr_nx;
      wb_valid <= wb_valid_nx;
      wb_data  <= wb_data_nx;
      wb_rt    <= wb_rt_nx;
      adel     <= adel_nx;
      bus_err  <= bus_err_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_ext_unit.sv
// ============================================================================
// tb_load_ext_unit : self-checking bench for load_ext_unit (TIMEOUT = 4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_ext_unit;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_instr = '0;
  logic [31:0] ld_addr = '0;
  logic        flush = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_rvalid = 1'b0;
  logic        ld_ready, bus_req, wb_valid, adel, bus_err, busy;
  logic [31:0] bus_addr, wb_data;
  logic [4:0]  wb_rt;

  int n_cmp = 0;
  int n_fail = 0;

  load_ext_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_instr(ld_instr), .ld_addr(ld_addr),
    .ld_ready(ld_ready), .flush(flush), .bus_req(bus_req), .bus_addr(bus_addr),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rt(wb_rt), .adel(adel), .bus_err(bus_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: pick the addressed lane with shifts/masks and extend arithmetically.
  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] v;
    int unsigned sh;
    sh = addr % 4;
    case (op)
      LB, LBU: begin
        v = (word >> (8 * sh)) & 32'hFF;
        if (op == LB && v >= 32'd128) v = v - 32'd256;
      end
      LH, LHU: begin
        v = (word >> (16 * (sh / 2))) & 32'hFFFF;
        if (op == LH && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] addr);
    ld_valid = 1'b1;
    ld_instr = {op, 5'($urandom), rt, 16'($urandom)};
    ld_addr  = addr;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", ld_ready); end
    n_cmp++; if ({bus_req, wb_valid, adel, bus_err, busy} !== 5'b0) begin n_fail++;
      $display("FAIL reset_flags got=%b want=00000", {bus_req, wb_valid, adel, bus_err, busy}); end
    n_cmp++; if ({bus_addr, wb_data, wb_rt} !== 69'd0) begin n_fail++;
      $display("FAIL reset_data got=%h/%h/%h want=0", bus_addr, wb_data, wb_rt); end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_lb_directed();
    drive_req(LB, 5'd7, 32'h0000_0003);
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h0) begin n_fail++;
      $display("FAIL lb_req got=%b/%h want=1/00000000", bus_req, bus_addr); end
    repeat (2) step();
    bus_rdata = 32'h80FF_1234; bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_FF80 || wb_rt !== 5'd7) begin n_fail++;
      $display("FAIL lb_wb got=%b/%h/%0d want=1/ffffff80/7", wb_valid, wb_data, wb_rt); end
    n_cmp++; if (bus_req !== 1'b0 || ld_ready !== 1'b1) begin n_fail++;
      $display("FAIL lb_done got=%b/%b want=0/1", bus_req, ld_ready); end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL lb_pulse got=%b want=0", wb_valid); end
  endtask

  task automatic test_lhu_directed();
    drive_req(LHU, 5'd12, 32'h0000_0012);
    n_cmp++; if (bus_addr !== 32'h0000_0010) begin n_fail++;
      $display("FAIL lhu_addr got=%h want=00000010", bus_addr); end
    bus_rdata = 32'h8001_7FFF; bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h0000_8001) begin n_fail++;
      $display("FAIL lhu_wb got=%b/%h want=1/00008001", wb_valid, wb_data); end
    step();
  endtask

  task automatic test_adel();
    drive_req(LW, 5'd3, 32'h0000_0006);
    n_cmp++; if (adel !== 1'b1 || bus_req !== 1'b0 || ld_ready !== 1'b1) begin n_fail++;
      $display("FAIL adel_lw got=%b/%b/%b want=1/0/1", adel, bus_req, ld_ready); end
    step();
    n_cmp++; if (adel !== 1'b0 || bus_req !== 1'b0) begin n_fail++;
      $display("FAIL adel_pulse got=%b/%b want=0/0", adel, bus_req); end
    drive_req(($urandom_range(0, 1) != 0) ? LH : LHU, 5'd4, {$urandom} | 32'h1);
    n_cmp++; if (adel !== 1'b1 || bus_req !== 1'b0) begin n_fail++;
      $display("FAIL adel_half got=%b/%b want=1/0", adel, bus_req); end
    drive_req(LB, 5'd4, 32'h0000_0007);
    n_cmp++; if (adel !== 1'b0 || bus_req !== 1'b1) begin n_fail++;
      $display("FAIL adel_lb_ok got=%b/%b want=0/1", adel, bus_req); end
    bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
    step();
  endtask

  task automatic test_nonload();
    drive_req(6'h2B, 5'd9, 32'h0000_0001);
    n_cmp++; if (bus_req !== 1'b0 || adel !== 1'b0 || ld_ready !== 1'b1) begin n_fail++;
      $display("FAIL nonload got=%b/%b/%b want=0/0/1", bus_req, adel, ld_ready); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++; if (ld_ready !== 1'b1 || wb_valid !== 1'b0) begin n_fail++;
      $display("FAIL idle_flush got=%b/%b want=1/0", ld_ready, wb_valid); end
  endtask

  task automatic test_random_back_to_back();
    logic [5:0]  ops [5] = '{LB, LH, LW, LBU, LHU};
    logic [5:0]  op;
    logic [31:0] addr, data, exp;
    logic [4:0]  rt;
    int          dly;
    for (int i = 0; i < 40; i++) begin
      op   = ops[$urandom_range(0, 4)];
      addr = $urandom;
      if (op == LW) addr[1:0] = 2'b00;
      else if (op == LH || op == LHU) addr[0] = 1'b0;
      rt   = 5'($urandom);
      data = $urandom;
      dly  = $urandom_range(0, 3);
      exp  = ref_load(op, addr, data);
      n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready i=%0d got=%b want=1", i, ld_ready); end
      drive_req(op, rt, addr);
      n_cmp++; if (bus_req !== 1'b1 || bus_addr !== (addr & 32'hFFFF_FFFC) || ld_ready !== 1'b0) begin n_fail++;
        $display("FAIL rnd_req i=%0d got=%b/%h/%b want=1/%h/0", i, bus_req, bus_addr, ld_ready, addr & 32'hFFFF_FFFC); end
      for (int k = 0; k < dly; k++) begin
        step();
        n_cmp++; if (wb_valid !== 1'b0 || bus_req !== 1'b1) begin n_fail++;
          $display("FAIL rnd_wait i=%0d got=%b/%b want=0/1", i, wb_valid, bus_req); end
      end
      bus_rdata = data; bus_rvalid = 1'b1;
      step();
      bus_rvalid = 1'b0;
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== exp || wb_rt !== rt) begin n_fail++;
        $display("FAIL rnd_wb i=%0d op=%h addr=%h rd=%h got=%b/%h/%0d want=1/%h/%0d",
                 i, op, addr, data, wb_valid, wb_data, wb_rt, exp, rt); end
    end
    step();
  endtask

  task automatic test_flush();
    drive_req(LW, 5'd5, 32'h0000_0100);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++; if (bus_req !== 1'b0 || ld_ready !== 1'b0) begin n_fail++;
      $display("FAIL flush_drain got=%b/%b want=0/0", bus_req, ld_ready); end
    repeat (3) begin
      step();
      n_cmp++; if (wb_valid !== 1'b0 || ld_ready !== 1'b0) begin n_fail++;
        $display("FAIL flush_hold got=%b/%b want=0/0", wb_valid, ld_ready); end
    end
    bus_rdata = 32'hDEAD_BEEF; bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
    n_cmp++; if (wb_valid !== 1'b0 || ld_ready !== 1'b1) begin n_fail++;
      $display("FAIL flush_late got=%b/%b want=0/1", wb_valid, ld_ready); end
    // flush and rvalid in the same cycle
    drive_req(LBU, 5'd6, 32'h0000_0201);
    flush = 1'b1; bus_rvalid = 1'b1;
    step();
    flush = 1'b0; bus_rvalid = 1'b0;
    n_cmp++; if (wb_valid !== 1'b0 || ld_ready !== 1'b1 || bus_req !== 1'b0) begin n_fail++;
      $display("FAIL flush_same got=%b/%b/%b want=0/1/0", wb_valid, ld_ready, bus_req); end
    // flush then no data: drain times out silently
    drive_req(LH, 5'd8, 32'h0000_0302);
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();
    n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL drain_tmo_early got=%b want=0", ld_ready); end
    step();
    n_cmp++; if (ld_ready !== 1'b1 || bus_err !== 1'b0) begin n_fail++;
      $display("FAIL drain_tmo got=%b/%b want=1/0", ld_ready, bus_err); end
  endtask

  task automatic test_timeout();
    drive_req(LW, 5'd9, 32'h0000_0400);
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++; if (bus_err !== 1'b0 || bus_req !== 1'b1) begin n_fail++;
        $display("FAIL tmo_wait k=%0d got=%b/%b want=0/1", k, bus_err, bus_req); end
    end
    step();
    n_cmp++; if (bus_err !== 1'b1 || bus_req !== 1'b0 || ld_ready !== 1'b1 || wb_valid !== 1'b0) begin n_fail++;
      $display("FAIL tmo_err got=%b/%b/%b/%b want=1/0/1/0", bus_err, bus_req, ld_ready, wb_valid); end
    step();
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse got=%b want=0", bus_err); end
  endtask

  task automatic test_async_reset();
    drive_req(LW, 5'd10, 32'h0000_0500);
    step();
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus_req !== 1'b0 || ld_ready !== 1'b1 || bus_addr !== 32'h0 || wb_rt !== 5'd0) begin n_fail++;
      $display("FAIL async_rst got=%b/%b/%h/%0d want=0/1/0/0", bus_req, ld_ready, bus_addr, wb_rt); end
    step();
    reset = 1'b1;
    bus_rdata = 32'h1234_5678; bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
    n_cmp++; if (wb_valid !== 1'b0 || bus_req !== 1'b0) begin n_fail++;
      $display("FAIL rst_late_rvalid got=%b/%b want=0/0", wb_valid, bus_req); end
  endtask

  initial begin
    test_reset();
    test_lb_directed();
    test_lhu_directed();
    test_adel();
    test_nonload();
    test_random_back_to_back();
    test_flush();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
